// File: rtl/worm_move_seq.sv
// Worm position sequencer: queues up/down step commands in a small FIFO and
// commits one saturating move every two cycles until the worm reaches TARGET.
module worm_move_seq #(
    parameter int         DEPTH  = 4,
    parameter logic [4:0] TARGET = 5'd15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_steps,
    input  logic       cmd_dir,
    output logic       cmd_ready,
    output logic [4:0] pos,
    output logic       pos_valid,
    output logic       clamped,
    output logic [7:0] move_count,
    output logic       done
);

    localparam int             AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]    DEPTH_CNT = DEPTH[AW:0];
    localparam logic [4:0]     POS_MAX   = 5'd15;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // {dir, steps} of the move that commits on the edge leaving LOAD
    logic [2:0]    cmd_reg;
    logic [4:0]    steps_ext;
    logic [4:0]    sum;
    logic [4:0]    pos_nxt;
    logic          clamp_nxt;
    logic          commit;

    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign cmd_ready = !full && (state != S_DONE) && !restart;
    assign push      = cmd_valid && cmd_ready;
    assign commit    = (state == S_LOAD);

    // The FIFO head is popped on the edge that enters LOAD, so LOAD always
    // holds a loaded command and the edge leaving it commits that move.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    state_nxt = S_LOAD;
                    pop       = 1'b1;
                end
            end
            S_LOAD: state_nxt = S_EXEC;
            S_EXEC: begin
                if (pos == TARGET) begin
                    state_nxt = S_DONE;
                end else if (!empty) begin
                    state_nxt = S_LOAD;
                    pop       = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_DONE;
        endcase
    end

    assign steps_ext = {3'b000, cmd_reg[1:0]};
    assign sum       = pos + steps_ext;

    always_comb begin
        pos_nxt   = sum;
        clamp_nxt = 1'b0;
        if (!cmd_reg[2]) begin
            if (sum > POS_MAX) begin
                pos_nxt   = POS_MAX;
                clamp_nxt = 1'b1;
            end
        end else if (steps_ext > pos) begin
            pos_nxt   = 5'd0;
            clamp_nxt = 1'b1;
        end else begin
            pos_nxt   = pos - steps_ext;
        end
    end

    // NOTE: storage array has no reset; emptiness is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_dir, cmd_steps};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (restart) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cmd_reg    <= '0;
            pos        <= '0;
            pos_valid  <= 1'b0;
            clamped    <= 1'b0;
            move_count <= '0;
            done       <= 1'b0;
        end else if (restart) begin
            state      <= S_IDLE;
            cmd_reg    <= '0;
            pos        <= '0;
            pos_valid  <= 1'b0;
            clamped    <= 1'b0;
            move_count <= '0;
            done       <= 1'b0;
        end else begin
            state     <= state_nxt;
            pos_valid <= commit;
            clamped   <= commit && clamp_nxt;
            if (pop) begin
                cmd_reg <= mem[rd_ptr];
            end
            if (commit) begin
                pos <= pos_nxt;
                if (move_count != 8'hFF) begin
                    move_count <= move_count + 8'd1;
                end
                if (pos_nxt == TARGET) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_worm_move_seq.sv
// Self-checking bench for worm_move_seq: vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_worm_move_seq;

    localparam int         DEPTH  = 4;
    localparam logic [4:0] TARGET = 5'd15;

    logic       clk;
    logic       rst_n;
    logic       restart;
    logic       cmd_valid;
    logic [1:0] cmd_steps;
    logic       cmd_dir;
    logic       cmd_ready;
    logic [4:0] pos;
    logic       pos_valid;
    logic       clamped;
    logic [7:0] move_count;
    logic       done;

    worm_move_seq #(.DEPTH(DEPTH), .TARGET(TARGET)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart    (restart),
        .cmd_valid  (cmd_valid),
        .cmd_steps  (cmd_steps),
        .cmd_dir    (cmd_dir),
        .cmd_ready  (cmd_ready),
        .pos        (pos),
        .pos_valid  (pos_valid),
        .clamped    (clamped),
        .move_count (move_count),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending commands, one optional command that
    // has been taken from the queue and commits on the next edge, and the
    // game state. A command waits one edge after being taken, then commits.
    int  m_q[$];
    bit  m_has_pend;
    int  m_pend;
    int  m_pos;
    int  m_cnt;
    bit  m_valid;
    bit  m_clamp;
    bit  m_done;
    bit  m_parked;   // game won and the win already seen for one full cycle

    function automatic void model_reset();
        m_q.delete();
        m_has_pend = 0;
        m_pend     = 0;
        m_pos      = 0;
        m_cnt      = 0;
        m_valid    = 0;
        m_clamp    = 0;
        m_done     = 0;
        m_parked   = 0;
    endfunction

    function automatic bit model_ready(input bit rs);
        return (m_q.size() < DEPTH) && !m_parked && !rs;
    endfunction

    function automatic void model_edge(input bit v, input int s, input bit d,
                                       input bit rs, output bit acc);
        bit take;
        bit old_done;
        int tgt;
        acc = v && model_ready(rs);
        if (rs) begin
            model_reset();
            return;
        end
        take     = !m_has_pend && !m_done && (m_q.size() > 0);
        old_done = m_done;
        m_valid  = 0;
        m_clamp  = 0;
        if (m_has_pend) begin
            tgt = ((m_pend >> 2) != 0) ? m_pos - (m_pend & 3) : m_pos + (m_pend & 3);
            if (tgt > 15) begin
                m_pos   = 15;
                m_clamp = 1;
            end else if (tgt < 0) begin
                m_pos   = 0;
                m_clamp = 1;
            end else begin
                m_pos = tgt;
            end
            m_valid = 1;
            if (m_cnt < 255) m_cnt++;
            if (m_pos == int'(TARGET)) m_done = 1;
            m_has_pend = 0;
        end
        if (take) begin
            m_pend     = m_q.pop_front();
            m_has_pend = 1;
        end
        if (acc) m_q.push_back(int'(d) * 4 + s);
        m_parked = old_done;
    endfunction

    // One clock cycle: drive at the falling edge, check cmd_ready, take the
    // rising edge, compare registered outputs, return at the next falling edge.
    task automatic step(input bit v, input int s, input bit d, input bit rs, output bit acc);
        cmd_valid = v;
        cmd_steps = s[1:0];
        cmd_dir   = d;
        restart   = rs;
        #1;
        check("cmd_ready", int'(cmd_ready), int'(model_ready(rs)));
        @(posedge clk);
        model_edge(v, s, d, rs, acc);
        #1;
        check("pos", int'(pos), m_pos);
        check("pos_valid", int'(pos_valid), int'(m_valid));
        check("clamped", int'(clamped), int'(m_clamp));
        check("move_count", int'(move_count), m_cnt);
        check("done", int'(done), int'(m_done));
        @(negedge clk);
    endtask

    typedef struct {
        bit       v;
        int       st;
        bit       dr;
        bit       rs;
        int       e_pos;
        bit       e_val;
        bit       e_clp;
        int       e_cnt;
        bit       e_done;
        bit       e_rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit v, input int st, input bit dr, input bit rs,
                                input int p, input bit val, input bit clp,
                                input int cnt, input bit dn, input bit rdy);
        vec_t e;
        e.v = v; e.st = st; e.dr = dr; e.rs = rs;
        e.e_pos = p; e.e_val = val; e.e_clp = clp; e.e_cnt = cnt;
        e.e_done = dn; e.e_rdy = rdy;
        tbl.push_back(e);
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        int accepted;
        int guard;
        bit saw_block;
        int pos_hist[10];
        int valid_seen;

        clk       = 0;
        rst_n     = 0;
        restart   = 0;
        cmd_valid = 0;
        cmd_steps = 0;
        cmd_dir   = 0;
        model_reset();

        // Table: latency, saturation up, DONE entry, restart, borrow, step 0, exact landing.
        add(1,3,0,0,  0,0,0,0,0,1);
        add(0,0,0,0,  0,0,0,0,0,1);
        add(0,0,0,0,  3,1,0,1,0,1);
        add(0,0,0,0,  3,0,0,1,0,1);
        add(1,3,0,0,  3,0,0,1,0,1);
        add(1,3,0,0,  3,0,0,1,0,1);
        add(1,3,0,0,  6,1,0,2,0,1);
        add(1,2,0,0,  6,0,0,2,0,1);
        add(0,0,0,0,  9,1,0,3,0,1);
        add(0,0,0,0,  9,0,0,3,0,1);
        add(0,0,0,0, 12,1,0,4,0,1);
        add(0,0,0,0, 12,0,0,4,0,1);
        add(0,0,0,0, 14,1,0,5,0,1);
        add(0,0,0,0, 14,0,0,5,0,1);
        add(1,3,0,0, 14,0,0,5,0,1);
        add(0,0,0,0, 14,0,0,5,0,1);
        add(0,0,0,0, 15,1,1,6,1,1);
        add(0,0,0,0, 15,0,0,6,1,0);
        add(1,3,1,0, 15,0,0,6,1,0);
        add(0,0,0,1,  0,0,0,0,0,0);
        add(0,0,0,0,  0,0,0,0,0,1);
        add(1,2,0,0,  0,0,0,0,0,1);
        add(0,0,0,0,  0,0,0,0,0,1);
        add(0,0,0,0,  2,1,0,1,0,1);
        add(1,3,1,0,  2,0,0,1,0,1);
        add(0,0,0,0,  2,0,0,1,0,1);
        add(0,0,0,0,  0,1,1,2,0,1);
        add(1,0,0,0,  0,0,0,2,0,1);
        add(0,0,0,0,  0,0,0,2,0,1);
        add(0,0,0,0,  0,1,0,3,0,1);
        add(1,3,0,0,  0,0,0,3,0,1);
        add(0,0,0,0,  0,0,0,3,0,1);
        add(0,0,0,0,  3,1,0,4,0,1);
        add(1,3,1,0,  3,0,0,4,0,1);
        add(0,0,0,0,  3,0,0,4,0,1);
        add(0,0,0,0,  0,1,0,5,0,1);
        add(0,0,0,0,  0,0,0,5,0,1);

        // Asynchronous reset holds everything clear with no clock dependency.
        #12;
        check("rst_pos", int'(pos), 0);
        check("rst_pos_valid", int'(pos_valid), 0);
        check("rst_clamped", int'(clamped), 0);
        check("rst_move_count", int'(move_count), 0);
        check("rst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("ready_after_reset", int'(cmd_ready), 1);

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].st, tbl[i].dr, tbl[i].rs, acc);
            check($sformatf("tbl%0d_pos", i), int'(pos), tbl[i].e_pos);
            check($sformatf("tbl%0d_valid", i), int'(pos_valid), int'(tbl[i].e_val));
            check($sformatf("tbl%0d_clamped", i), int'(clamped), int'(tbl[i].e_clp));
            check($sformatf("tbl%0d_count", i), int'(move_count), tbl[i].e_cnt);
            check($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].e_done));
            check($sformatf("tbl%0d_ready", i), int'(cmd_ready), int'(tbl[i].e_rdy));
        end

        // Back-to-back up-1 commands: pos steps on alternate cycles.
        step(0, 0, 0, 1, acc);
        for (int i = 0; i < 10; i++) begin
            step(i < 4, 1, 0, 0, acc);
            if (i < 4) check("bp_accept", int'(acc), 1);
            pos_hist[i] = int'(pos);
        end
        check("bp_pos_a", pos_hist[2], 1);
        check("bp_pos_b", pos_hist[4], 2);
        check("bp_pos_c", pos_hist[6], 3);
        check("bp_pos_d", pos_hist[8], 4);
        check("bp_count", int'(move_count), 4);

        // Hold cmd_valid with zero-step moves until the FIFO fills and stalls.
        accepted  = 0;
        guard     = 0;
        saw_block = 0;
        while (accepted < 8 && guard < 40) begin
            step(1, 0, 0, 0, acc);
            if (acc) accepted++;
            else saw_block = 1;
            guard++;
        end
        check("fill_accepted", accepted, 8);
        check("fill_saw_full", int'(saw_block), 1);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, acc);
        check("fill_count", int'(move_count), 12);
        check("fill_pos", int'(pos), 4);

        // Reach TARGET with up-3 x5 and two commands left queued behind it.
        step(0, 0, 0, 1, acc);
        accepted = 0;
        guard    = 0;
        while (accepted < 7 && guard < 40) begin
            step(1, (accepted < 5) ? 3 : 1, (accepted == 6), 0, acc);
            if (acc) accepted++;
            guard++;
        end
        check("done_accepted", accepted, 7);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, acc);
        check("done_flag", int'(done), 1);
        check("done_pos", int'(pos), 15);
        check("done_count", int'(move_count), 5);
        check("done_ready", int'(cmd_ready), 0);
        step(0, 0, 0, 1, acc);
        step(0, 0, 0, 0, acc);
        check("restart_pos", int'(pos), 0);
        check("restart_done", int'(done), 0);
        check("restart_count", int'(move_count), 0);
        check("restart_ready", int'(cmd_ready), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(9, 0) < 7, $urandom_range(3, 0), $urandom_range(1, 0),
                 $urandom_range(59, 0) == 0, acc);
        end

        // Asynchronous reset while a move has just committed and more are queued.
        step(0, 0, 0, 1, acc);
        step(1, 3, 0, 0, acc);
        step(1, 2, 0, 0, acc);
        step(1, 1, 0, 0, acc);
        check("arst_pre_valid", int'(pos_valid), 1);
        check("arst_pre_pos", int'(pos), 3);
        cmd_valid = 0;
        #2;
        rst_n = 0;
        #1;
        check("arst_pos", int'(pos), 0);
        check("arst_pos_valid", int'(pos_valid), 0);
        check("arst_clamped", int'(clamped), 0);
        check("arst_count", int'(move_count), 0);
        check("arst_done", int'(done), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("arst_ready", int'(cmd_ready), 1);
        valid_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0, acc);
            if (pos_valid) valid_seen++;
        end
        check("arst_no_pulse", valid_seen, 0);
        check("arst_pos_after", int'(pos), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/worm_move_seq.md
WORM_MOVE_SEQ -- requirements
Module: worm_move_seq

Interface
REQ-001 Parameter DEPTH, default 4, gives the command FIFO depth in entries (power of 2).
REQ-002 Parameter TARGET, default 5'd15, gives the winning position.
REQ-003 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, is the reset: asynchronous, active-low.
REQ-005 Port restart, input, 1, is a synchronous game restart, active-high.
REQ-006 Port cmd_valid, input, 1, indicates a move command is offered.
REQ-007 Port cmd_steps, input, 2, is the step count (0..3).
REQ-008 Port cmd_dir, input, 1, selects the direction: 0 = add (up), 1 = subtract (down).
REQ-009 Port cmd_ready, output, 1, indicates the block can accept a command this cycle.
REQ-010 Port pos, output, 5, is the committed worm position, always in the range 0..15.
REQ-011 Port pos_valid, output, 1, is a one-cycle pulse when pos updates.
REQ-012 Port clamped, output, 1, is a one-cycle pulse, coincident with pos_valid, when the move saturated.
REQ-013 Port move_count, output, 8, counts committed moves and saturates at 255.
REQ-014 Port done, output, 1, is sticky and high once pos == TARGET.

Function
REQ-015 A command SHALL be accepted on a rising edge where cmd_valid && cmd_ready.
- {cmd_dir, cmd_steps} is pushed into the FIFO.
REQ-016 cmd_ready SHALL equal !fifo_full && state != DONE && !restart.
REQ-017 The FSM SHALL have the states IDLE, LOAD, EXEC and DONE, with the following transitions:
- IDLE->LOAD when the FIFO is non-empty.
- LOAD pops the FIFO head into the command register, then ->EXEC.
- EXEC commits the move, then:
  - ->DONE if the new pos == TARGET;
  - else ->LOAD if the FIFO is non-empty;
  - else ->IDLE.
REQ-018 Latency SHALL be fixed:
- a command accepted at edge N into an empty FIFO in IDLE is popped at edge N+1 and committed at edge N+2;
- pos, pos_valid and clamped are visible after edge N+2.
REQ-019 Throughput SHALL be one move per 2 cycles.
REQ-020 The EXEC arithmetic SHALL use a 5-bit next value:
- Up: next = pos + steps; if next > 15, pos <= 15 and clamped = 1.
- Down: next = pos - steps; on borrow (steps > pos), pos <= 0 and clamped = 1.
- Otherwise pos <= next and clamped = 0.
REQ-021 A move with steps == 0 SHALL:
- commit with pos unchanged;
- pulse pos_valid;
- leave clamped = 0;
- increment move_count.
REQ-022 Landing exactly on 15 or 0 without overshoot SHALL NOT assert clamped.
REQ-023 move_count SHALL increment by 1 on every EXEC and hold at 255.
REQ-024 The FIFO SHALL accept a push and a pop in the same cycle, with occupancy unchanged.
REQ-025 No push SHALL occur when full.
REQ-026 The FIFO pointers SHALL wrap modulo DEPTH.
REQ-027 In DONE:
- done = 1;
- commands already in the FIFO remain and are not executed;
- cmd_ready = 0;
- pos holds.
REQ-028 restart SHALL take effect at the next edge in any state, and has priority over push, pop and EXEC:
- FIFO flushed;
- pos = 0, move_count = 0, done = 0;
- pos_valid = 0, clamped = 0;
- state IDLE.
REQ-029 pos_valid and clamped SHALL be registered outputs, high for exactly one cycle per EXEC.

Reset
REQ-030 While rst_n = 0, the block SHALL asynchronously force the following, independent of clk:
- state IDLE;
- FIFO empty;
- pos = 0, move_count = 0;
- done = 0, pos_valid = 0, clamped = 0.
REQ-031 Immediately after rst_n deasserts, cmd_ready SHALL be 1.
REQ-032 Reset asserted mid-operation SHALL discard the in-flight command and all queued commands.

Verification
REQ-033 Latency check: reset, then push up 3 at edge N.
- Required: pos = 3, pos_valid = 1, clamped = 0 after edge N+2.
- Required: move_count = 1.
REQ-034 Saturation: from pos = 14, push up 3, then down 3, then down 3 with pos at 2.
- Required: pos = 15 with clamped = 1, and done = 1 since TARGET = 15.
- After restart, from pos = 2, down 3 → pos = 0 with clamped = 1.
REQ-035 Backpressure: hold cmd_valid with four up-1 commands back-to-back.
- Required: cmd_ready = 0 while the FIFO is full.
- Required: no command is lost or duplicated.
- Required: pos steps 1, 2, 3, 4 on alternate cycles, ending at move_count = 4.
REQ-036 DONE behaviour: reach 15 via up 3 ×5 with two extra commands queued.
- Required: done = 1 and pos holds 15.
- Required: the queued commands are not executed and cmd_ready = 0.
REQ-037 restart and steps == 0 behaviour:
- restart while in DONE: pos = 0, done = 0, move_count = 0, cmd_ready = 1 on the next cycle.
- up 0: pos unchanged, pos_valid = 1, clamped = 0.
REQ-038 Async reset mid-EXEC: assert rst_n = 0 between edges.
- Required: all outputs clear without a clock edge.
- Required: there is no pos_valid pulse after reset.
